// File: rtl/mcs_fpro_bridge_wt.sv
// MCS IO bus to FPro MMIO/video bridge: registers each access, decodes the window,
// waits RD_LAT cycles for slave read data and answers every strobe with one io_ready.
module mcs_fpro_bridge_wt #(
   parameter logic [31:0] BRG_BASE = 32'hc000_0000,
   parameter int          RD_LAT   = 1,
   parameter bit          VIDEO_EN = 1'b1,
   parameter logic [31:0] ERR_DATA = 32'hdead_beef
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_addr_strobe,
   input  logic        io_read_strobe,
   input  logic        io_write_strobe,
   input  logic [3:0]  io_byte_enable,
   input  logic [31:0] io_address,
   input  logic [31:0] io_write_data,
   output logic [31:0] io_read_data,
   output logic        io_ready,
   output logic        fp_mmio_cs,
   output logic        fp_video_cs,
   output logic        fp_wr,
   output logic        fp_rd,
   output logic [20:0] fp_addr,
   output logic [31:0] fp_wr_data,
   output logic [3:0]  fp_be,
   input  logic [31:0] fp_rd_data,
   output logic        busy,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} state_t;

   localparam logic [2:0] LAT_M1 = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

   state_t     state, state_next;
   logic       req_wr, req_map;
   logic [2:0] lat_cnt;
   logic       accept, in_win, dec_mmio, dec_video, dec_map;
   logic       load_err, load_slave;

   // The address strobe carries no information beyond the read/write strobes.
   logic unused_ok;
   assign unused_ok = ^{io_addr_strobe, io_address[1:0]};

   assign in_win    = (io_address[31:24] == BRG_BASE[31:24]);
   assign dec_mmio  = in_win & ~io_address[23];
   assign dec_video = in_win & io_address[23] & VIDEO_EN;
   assign dec_map   = dec_mmio | dec_video;
   assign accept    = (state == IDLE) & (io_read_strobe | io_write_strobe);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_err   = 1'b0;
      load_slave = 1'b0;
      case (state)
         IDLE:  if (accept) state_next = ISSUE;
         ISSUE: begin
            if (!req_wr && req_map && RD_LAT != 0) state_next = RWAIT;
            else                                    state_next = DONE;
            load_err   = !req_wr && !req_map;
            load_slave = !req_wr && req_map && RD_LAT == 0;
         end
         RWAIT: if (lat_cnt == 3'd0) begin
            state_next = DONE;
            load_slave = 1'b1;
         end
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobe pulses are computed from the decode in IDLE so they land in ISSUE as registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_wr       <= 1'b0;
         req_map      <= 1'b0;
         lat_cnt      <= 3'd0;
         io_read_data <= 32'd0;
         io_ready     <= 1'b0;
         fp_mmio_cs   <= 1'b0;
         fp_video_cs  <= 1'b0;
         fp_wr        <= 1'b0;
         fp_rd        <= 1'b0;
         fp_addr      <= 21'd0;
         fp_wr_data   <= 32'd0;
         fp_be        <= 4'd0;
         busy         <= 1'b0;
         err_cnt      <= 8'd0;
      end else begin
         io_ready    <= (state_next == DONE);
         busy        <= (state_next != IDLE);
         fp_mmio_cs  <= accept & dec_mmio;
         fp_video_cs <= accept & dec_video;
         fp_wr       <= accept & io_write_strobe & dec_map;
         fp_rd       <= accept & ~io_write_strobe & dec_map;
         if (accept) begin
            req_wr     <= io_write_strobe;
            req_map    <= dec_map;
            fp_addr    <= io_address[22:2];
            fp_wr_data <= io_write_data;
            fp_be      <= io_byte_enable;
         end
         if (state == ISSUE) lat_cnt <= LAT_M1;
         else if (state == RWAIT && lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
         if (state == ISSUE && !req_map && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
         if (load_err)        io_read_data <= ERR_DATA;
         else if (load_slave) io_read_data <= fp_rd_data;
      end
   end

endmodule

// File: doc/mcs_fpro_bridge_wt.md
# mcs_fpro_bridge_wt

Parametrised successor to the MicroBlaze MCS–to–FPro bus bridge. It sits between the MCS IO bus and the FPro MMIO/video subsystems and registers every transaction. It adds a configurable slave read latency, byte-enable pass-through, and decode of out-of-window or unmapped accesses. Every MCS strobe receives exactly one `io_ready` pulse, so the CPU never hangs.

## Interface

- `BRG_BASE`, 32'hc000_0000, bridge window base; the window is the 16 MB region `io_address[31:24] == BRG_BASE[31:24]`.
- `RD_LAT`, 1, slave read latency in cycles (0..7) from the `fp_rd` pulse to valid `fp_rd_data`.
- `VIDEO_EN`, 1, enables the video region; when 0, video-region accesses are treated as unmapped.
- `ERR_DATA`, 32'hdead_beef, read data returned for unmapped or out-of-window reads.

Ports:

- `clk` in 1: system clock (100 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `io_addr_strobe` in 1: MCS address strobe.
- `io_read_strobe` in 1: MCS read request.
- `io_write_strobe` in 1: MCS write request.
- `io_byte_enable` in 4: MCS byte enables.
- `io_address` in 32: MCS byte address.
- `io_write_data` in 32: MCS write data.
- `io_read_data` out 32: read data returned to MCS.
- `io_ready` out 1: one-cycle transaction-complete pulse.
- `fp_mmio_cs` out 1: MMIO region select.
- `fp_video_cs` out 1: video region select.
- `fp_wr` out 1: one-cycle write pulse.
- `fp_rd` out 1: one-cycle read pulse.
- `fp_addr` out 21: word address, taken from `io_address[22:2]`.
- `fp_wr_data` out 32: registered write data.
- `fp_be` out 4: registered byte enables.
- `fp_rd_data` in 32: shared slave read data.
- `busy` out 1: FSM is not IDLE.
- `err_cnt` out 8: saturating count of unmapped or out-of-window accesses.

## Operation

- Decode happens in IDLE, on the cycle a strobe is seen:
  - in-window with `io_address[23]=0` → MMIO region;
  - in-window with `io_address[23]=1` and `VIDEO_EN=1` → video region;
  - anything else → unmapped.
- Request latching: in IDLE, when `io_read_strobe` or `io_write_strobe` is high, the bridge latches address, data, byte enables, region and direction.
  - If both strobes are high, the access is a write.
  - `io_addr_strobe` alone is ignored.
- FSM states:
  - IDLE → ISSUE on an accepted strobe.
  - ISSUE → DONE for a write, unmapped access, or read with `RD_LAT=0`.
  - ISSUE → RWAIT for a read with `RD_LAT≥1`.
  - RWAIT → DONE after `RD_LAT` cycles; a down-counter is loaded with `RD_LAT-1` in ISSUE.
  - DONE → IDLE.
- ISSUE, mapped region:
  - exactly one of `fp_mmio_cs` or `fp_video_cs` is high for one cycle;
  - `fp_wr` or `fp_rd` is high for one cycle;
  - `fp_addr`, `fp_wr_data` and `fp_be` are valid.
- ISSUE, unmapped: no cs, `fp_wr` or `fp_rd` is asserted; `err_cnt` increments and saturates at 255.
- Read capture: `fp_rd_data` is sampled into `io_read_data`:
  - on the ISSUE cycle when `RD_LAT=0`;
  - on the last RWAIT cycle otherwise.
  - Unmapped reads load `ERR_DATA`.
- DONE: `io_ready=1` for one cycle.
- Hold behaviour:
  - `io_read_data` holds its value until the next read completes; writes leave it unchanged.
  - `fp_addr`, `fp_wr_data` and `fp_be` hold their last values between transactions.
- Strobes arriving while `busy=1` are ignored (no queueing, no error count).
- Reset mid-transaction: the FSM returns to IDLE, all pulses drop immediately, and no `io_ready` is issued.

## Timing

- All outputs are registered.
- Reset values: every output is 0, `err_cnt=0`, state IDLE.
- Cycle numbering: the strobe is in cycle 0.
  - Cycle 1: ISSUE (cs plus `fp_wr`/`fp_rd`).
  - Write or unmapped access: `io_ready` in cycle 2.
  - Read: `io_ready` in cycle 2+`RD_LAT`, with `io_read_data` valid in the same cycle.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- Earliest next accepted strobe: the cycle after DONE.
- `fp_wr` and `fp_rd` are never high together; no cs is high outside ISSUE.

## Test plan

- Write 0x0000_00a5 to 0xc000_0010, byte enables 4'hf → cycle 1: `fp_mmio_cs=1`, `fp_wr=1`, `fp_addr=4`, `fp_be=4'hf`; `io_ready` in cycle 2 only.
- `RD_LAT=3`: read 0xc080_0008 with slave driving 0x1234_5678 → `fp_video_cs=1`, `fp_rd=1`, `fp_addr=2` in cycle 1; `io_ready` in cycle 5 with `io_read_data=0x1234_5678`. Repeat with `RD_LAT=0` → `io_ready` in cycle 2.
- Read 0x4000_0000 (out of window) → no cs or `fp_rd` pulses; `io_ready` in cycle 2; `io_read_data=0xdead_beef`; `err_cnt=1`. With `VIDEO_EN=0`, a read of 0xc080_0000 gives the same response.
- Read and write strobes together on 0xc000_0004 → `fp_wr=1`, `fp_rd=0`. A strobe injected in cycle 1 is ignored: exactly one `io_ready`.
- 300 unmapped accesses → `err_cnt=255`.
- Assert `reset` in RWAIT (`RD_LAT=5`) → all outputs 0 and no `io_ready`. A following legal read completes normally.
